memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 110 +++++++++++
 tb/tb_memory_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-port word memory answering Controller read/write requests after a fixed latency,
// with a host program-load port usable while idle.
module memory_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        response_valid,
    output logic        busy,
    output logic        error,
    input  logic        load_enable,
    input  logic [31:0] load_address,
    input  logic [31:0] load_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [31:0]   mem [MEM_WORDS];

    logic [AW-1:0] req_idx;
    logic [31:0]   req_data;
    logic          req_write;
    logic          req_bad;

    logic [AW-1:0] addr_idx;
    logic          addr_bad;
    logic          accept;
    logic          conflict;
    logic [AW-1:0] rd_idx;
    logic          rd_is_read;
    logic          rd_bad;
    logic          unused_load_bits;

    assign addr_idx = address[AW+1:2];
    assign addr_bad = (address[1:0] != 2'b00) || ((address >> (AW + 2)) != '0);
    assign accept   = (state == IDLE) && !load_enable && (memory_read ^ memory_write);
    assign conflict = (state == IDLE) && !load_enable && memory_read && memory_write;
    assign unused_load_bits = ^load_address[31:AW];

    assign response_valid = (state == RESP);
    assign busy           = (state != IDLE);

    // Storage is read on the edge that enters RESP so the data appears together with the pulse;
    // with LATENCY=1 that edge is the acceptance edge, so the live request is used.
    assign rd_idx     = (state == IDLE) ? addr_idx    : req_idx;
    assign rd_is_read = (state == IDLE) ? memory_read : !req_write;
    assign rd_bad     = (state == IDLE) ? addr_bad    : req_bad;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = LAT_M1;
                    state_next = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            error     <= 1'b0;
            read_data <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (conflict || (accept && addr_bad)) error <= 1'b1;
            if (state_next == RESP && rd_is_read) read_data <= rd_bad ? 32'h0 : mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_idx   <= addr_idx;
            req_data  <= write_data;
            req_write <= memory_write;
            req_bad   <= addr_bad;
        end
    end

    // Reset gates both write sources so an aborted transaction never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == IDLE && load_enable)
                mem[load_address[AW-1:0]] <= load_data;
            else if (state == RESP && req_write && !req_bad)
                mem[req_idx] <= req_data;
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: stimulus pushes expected responses into a queue,
// a negedge monitor pops and checks them against response_valid/read_data.
module tb_memory_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_read, memory_write;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        response_valid, busy, error;
    logic        load_enable;
    logic [31:0] load_address, load_data;

    logic        s1_read;
    logic [31:0] s1_address;
    logic [31:0] s1_read_data;
    logic        s1_response_valid, s1_busy, s1_error;
    logic        s1_load_enable;
    logic [31:0] s1_load_address, s1_load_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          exp_cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_read = 32'h0;

    memory_responder #(.MEM_WORDS(4096), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .memory_read(memory_read), .memory_write(memory_write),
        .address(address), .write_data(write_data),
        .read_data(read_data), .response_valid(response_valid),
        .busy(busy), .error(error),
        .load_enable(load_enable), .load_address(load_address), .load_data(load_data)
    );

    memory_responder #(.MEM_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .memory_read(s1_read), .memory_write(1'b0),
        .address(s1_address), .write_data(32'h0),
        .read_data(s1_read_data), .response_valid(s1_response_valid),
        .busy(s1_busy), .error(s1_error),
        .load_enable(s1_load_enable), .load_address(s1_load_address), .load_data(s1_load_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the head of the queue in timing and data.
    always @(negedge clk) begin
        if (response_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", cyc, mon_e.exp_cyc);
                check("resp_data", read_data, mon_e.data);
            end
        end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
            void'(sb.pop_front());
            check("resp_timeout", 32'd0, 32'd1);
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        e.exp_cyc = cyc + LAT;
        e.data    = rd ? exp : last_read;
        sb.push_back(e);
        if (rd) last_read = exp;
        memory_read  = rd;
        memory_write = wr;
        address      = addr;
        write_data   = wd;
        @(posedge clk); #1;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            check("busy_inflight", busy, 32'd1);
            @(posedge clk); #1;
        end
        check("busy_after", busy, 32'd0);
    endtask

    task automatic load(input logic [31:0] la, input logic [31:0] ld);
        load_enable  = 1'b1;
        load_address = la;
        load_data    = ld;
        @(posedge clk); #1;
        load_enable  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read_data"}, read_data, 32'h0);
        check({tag, "_response_valid"}, response_valid, 32'd0);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_error"}, error, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b0;
        memory_read = 1'b0; memory_write = 1'b0; address = '0; write_data = '0;
        load_enable = 1'b0; load_address = '0; load_data = '0;
        s1_read = 1'b0; s1_address = '0;
        s1_load_enable = 1'b0; s1_load_address = '0; s1_load_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Request presented in the very first cycle with reset released.
        reset = 1'b1;
        req(1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0);

        load(32'd5, 32'h0000_0013);
        load(32'h10, 32'h0000_1234);
        load(32'd4096 + 32'd7, 32'h0000_0077);

        req(1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'h0000_0013);
        req(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_BABE, 32'h0);
        req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_BABE);
        req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111);
        req(1'b1, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0077);
        check("no_error_yet", error, 32'd0);

        // Read and write together: refused, flagged, never busy.
        memory_read = 1'b1; memory_write = 1'b1; address = 32'h14;
        @(posedge clk); #1;
        memory_read = 1'b0; memory_write = 1'b0;
        check("conflict_busy", busy, 32'd0);
        check("conflict_error", error, 32'd1);
        @(posedge clk); #1;
        check("conflict_busy_later", busy, 32'd0);

        req(1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0);
        check("misaligned_error", error, 32'd1);
        req(1'b1, 1'b0, 32'h0001_0014, 32'h0, 32'h0);
        req(1'b0, 1'b1, 32'h4000_0040, 32'hDEAD_BEEF, 32'h0);
        req(1'b0, 1'b1, 32'h0000_0041, 32'h5555_5555, 32'h0);
        req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_BABE);
        check("error_sticky", error, 32'd1);

        // Abort a write to 0x8 during WAIT.
        memory_write = 1'b1; address = 32'h8; write_data = 32'h2222_2222;
        @(posedge clk); #1;
        memory_write = 1'b0;
        check("abort_busy_wait", busy, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_reset_values("abort");
        last_read = 32'h0;
        req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111);

        // LATENCY=1 instance: read held high answers every other cycle.
        s1_load_enable = 1'b1; s1_load_address = 32'd3; s1_load_data = 32'hA5A5_0003;
        @(posedge clk); #1;
        s1_load_enable = 1'b0;
        s1_read = 1'b1; s1_address = 32'h0000_000C;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("lat1_pulse", s1_response_valid, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (s1_response_valid) begin
                pulses++;
                check("lat1_data", s1_read_data, 32'hA5A5_0003);
            end
        end
        s1_read = 1'b0;
        check("lat1_count", pulses, 32'd6);
        check("lat1_error", s1_error, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
